// File: rtl/des_s2p.sv
// Serial-to-parallel receiver: rebuilds MSB-first words aligned by a word strobe.
// Optional error counter (err_cnt, cnt_clr) enabled by defining DES_S2P_ERRCNT_EN.
module des_s2p #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sync,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             locked,
    output logic             align_err,
    output logic             ovf
`ifdef DES_S2P_ERRCNT_EN
    ,
    input  logic             cnt_clr,
    output logic [7:0]       err_cnt
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {HUNT, FILL, LOCK} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic             done, err_nxt, load, ovf_nxt;

    // NOTE: every output of this block is defaulted first so no path leaves a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        done      = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            HUNT: begin
                if (sync) begin
                    shreg_nxt = {{(WIDTH-1){1'b0}}, sin};
                    cnt_nxt   = CW'(1);
                    state_nxt = FILL;
                end
            end
            default: begin
                if (sync && cnt != '0) begin
                    // Strobe mid-word: drop the partial and restart on this bit.
                    err_nxt   = 1'b1;
                    shreg_nxt = {{(WIDTH-1){1'b0}}, sin};
                    cnt_nxt   = CW'(1);
                    state_nxt = FILL;
                end else if (state == LOCK && cnt == '0 && !sync) begin
                    err_nxt   = 1'b1;
                    shreg_nxt = '0;
                    cnt_nxt   = '0;
                    state_nxt = HUNT;
                end else begin
                    shreg_nxt = {shreg[WIDTH-2:0], sin};
                    if (cnt == LAST) begin
                        done      = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = LOCK;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
        endcase
    end

    // A completed word loads only if the holding register is free or draining now.
    assign load    = done && (!dout_valid || dout_ready);
    assign ovf_nxt = done && !load;
    assign locked  = (state == LOCK);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            cnt        <= '0;
            shreg      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            align_err  <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            shreg     <= shreg_nxt;
            align_err <= err_nxt;
            ovf       <= ovf_nxt;
            if (load) begin
                dout       <= shreg_nxt;
                dout_valid <= 1'b1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

`ifdef DES_S2P_ERRCNT_EN
    logic [1:0] inc;
    logic [8:0] sum;

    assign inc = {1'b0, err_nxt} + {1'b0, ovf_nxt};
    assign sum = {1'b0, err_cnt} + {7'b0, inc};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= '0;
        end else if (sum[8]) begin
            err_cnt <= 8'hFF;
        end else begin
            err_cnt <= sum[7:0];
        end
    end
`endif

endmodule
